sync_wr2rd_ptr: RTL and testbench

Parametrised write-to-read crossing stage for the asynchronous FIFO, in the read clock domain (`clk_out`). It synchronises the Gray-coded write pointer through a configurable flop chain and presents it in both Gray and binary form. It turns a toggle-encoded flush request into a single-cycle pulse and returns an acknowledge toggle. It also guards the crossing with a Gray-code integrity checker that is blanked around reset and flush.

---
 rtl/sync_wr2rd_ptr.sv | 151 +++++++++++++++
 tb/tb_sync_wr2rd_ptr.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/sync_wr2rd_ptr.sv
`default_nettype none
// ============================================================================
// Module      : sync_wr2rd_ptr
// Description : Write-to-read crossing stage of the asynchronous FIFO, in the
//               read clock domain (clk_out).
//               - Synchronises the Gray write pointer through SYNC_STAGES
//                 flops. Presents it as Gray and as registered binary.
//               - Converts a toggle-encoded flush request into a one-cycle
//                 pulse and returns an acknowledge toggle.
//               - Watches the synchronised pointer for multi-bit changes.
//                 This Gray integrity check is blanked around reset and flush.
// Ports       :
//   clk_out           in   read-domain clock, rising edge
//   reset             in   asynchronous, active-low reset
//   wptr_gray_i       in   [PW] Gray write pointer, from a write-domain flop
//   flush_tgl_i       in   flush request, one request per level change
//   err_clr_i         in   synchronous clear of gray_err_o
//   wptr_gray_sync_o  out  [PW] last stage of the pointer synchroniser
//   wptr_bin_sync_o   out  [PW] registered binary form of wptr_gray_sync_o
//   wptr_valid_o      out  synchronised pointer is usable (not blanked)
//   flush_pulse_o     out  one-cycle pulse per flush_tgl_i change
//   flush_ack_tgl_o   out  toggles once per flush_pulse_o
//   gray_err_o        out  sticky CDC integrity error
// Revision    : 1.0 - initial release
// ============================================================================
module sync_wr2rd_ptr #(
    parameter int ADDR_W      = 3,   // FIFO address width, 2..16
    parameter int SYNC_STAGES = 2    // synchroniser depth, 2..4
) (
    input  logic              clk_out,
    input  logic              reset,
    input  logic [ADDR_W:0]   wptr_gray_i,
    input  logic              flush_tgl_i,
    input  logic              err_clr_i,
    output logic [ADDR_W:0]   wptr_gray_sync_o,
    output logic [ADDR_W:0]   wptr_bin_sync_o,
    output logic              wptr_valid_o,
    output logic              flush_pulse_o,
    output logic              flush_ack_tgl_o,
    output logic              gray_err_o
);

    localparam int PW = ADDR_W + 1;
    // The counter must hold 2S+2; the width is sized for 2S+3 states.
    localparam int CNT_W = $clog2(2 * SYNC_STAGES + 3);
    localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(2 * SYNC_STAGES + 2);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    // ptr_q[0] is stage 1 and samples the input.
    // ptr_q[SYNC_STAGES-1] is stage S.
    logic [SYNC_STAGES-1:0][PW-1:0] ptr_q;
    logic [SYNC_STAGES-1:0]         tgl_q;
    logic                           tgl_prev_q;
    logic [PW-1:0]                  bin_q,   bin_d;
    logic                           pulse_q, pulse_d;
    logic                           ack_q,   ack_d;
    logic [CNT_W-1:0]               cnt_q,   cnt_d;
    logic                           valid_q, valid_d;
    logic                           err_q,   err_d;

    logic [PW-1:0]                  delta;
    logic                           multi_bit;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------

    // Gray to binary: each binary bit is the XOR of all Gray bits at or
    // above it. A running accumulator avoids a self-referencing vector.
    always_comb begin
        logic acc;
        acc   = 1'b0;
        bin_d = '0;
        for (int i = PW - 1; i >= 0; i--) begin
            acc      = acc ^ ptr_q[SYNC_STAGES-1][i];
            bin_d[i] = acc;
        end
    end

    always_comb begin
        // A level difference between the last toggle stage and its
        // delayed copy marks exactly one request.
        pulse_d = tgl_q[SYNC_STAGES-1] ^ tgl_prev_q;
        ack_d   = ack_q ^ pulse_d;

        // Blank counter: a flush (re)loads it, otherwise it decays to 0.
        if (pulse_d) begin
            cnt_d = BLANK_LOAD;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end

        valid_d = (cnt_q == '0) && !pulse_d;

        // delta is the change about to move into stage S on this edge.
        // So a flagged error rises together with the offending value.
        // More than one bit set  <=>  delta & (delta - 1) is nonzero.
        delta     = ptr_q[SYNC_STAGES-2] ^ ptr_q[SYNC_STAGES-1];
        multi_bit = (delta & (delta - PW'(1))) != '0;

        // A set wins over a simultaneous clear.
        err_d = ((cnt_q == '0) && multi_bit) || (err_q && !err_clr_i);
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    // The blank counter resets to its load value, not to zero.
    // The first edge after reset release therefore already counts down
    // the startup blank window. The window then ends together with the
    // flush-induced window.
    always_ff @(posedge clk_out or negedge reset) begin
        if (!reset) begin
            ptr_q      <= '0;
            tgl_q      <= '0;
            tgl_prev_q <= 1'b0;
            bin_q      <= '0;
            pulse_q    <= 1'b0;
            ack_q      <= 1'b0;
            cnt_q      <= BLANK_LOAD;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            ptr_q      <= {ptr_q[SYNC_STAGES-2:0], wptr_gray_i};
            tgl_q      <= {tgl_q[SYNC_STAGES-2:0], flush_tgl_i};
            tgl_prev_q <= tgl_q[SYNC_STAGES-1];
            bin_q      <= bin_d;
            pulse_q    <= pulse_d;
            ack_q      <= ack_d;
            cnt_q      <= cnt_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: all driven straight from flops
    // ------------------------------------------------------------------
    assign wptr_gray_sync_o = ptr_q[SYNC_STAGES-1];
    assign wptr_bin_sync_o  = bin_q;
    assign wptr_valid_o     = valid_q;
    assign flush_pulse_o    = pulse_q;
    assign flush_ack_tgl_o  = ack_q;
    assign gray_err_o       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_sync_wr2rd_ptr.sv
`default_nettype none
// ============================================================================
// Module      : tb_sync_wr2rd_ptr
// Description : Directed self-checking bench for sync_wr2rd_ptr
//               (ADDR_W=3, SYNC_STAGES=2). Inputs change 1 time unit after
//               a rising edge. Outputs are sampled at that same point.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_wr2rd_ptr;

    logic       clk_out = 1'b0;
    logic       reset   = 1'b0;
    logic [3:0] wptr_gray_i = '0;
    logic       flush_tgl_i = 1'b0;
    logic       err_clr_i   = 1'b0;
    logic [3:0] wptr_gray_sync_o;
    logic [3:0] wptr_bin_sync_o;
    logic       wptr_valid_o;
    logic       flush_pulse_o;
    logic       flush_ack_tgl_o;
    logic       gray_err_o;

    int n_checks = 0;
    int n_fail   = 0;

    sync_wr2rd_ptr #(
        .ADDR_W      (3),
        .SYNC_STAGES (2)
    ) dut (
        .clk_out          (clk_out),
        .reset            (reset),
        .wptr_gray_i      (wptr_gray_i),
        .flush_tgl_i      (flush_tgl_i),
        .err_clr_i        (err_clr_i),
        .wptr_gray_sync_o (wptr_gray_sync_o),
        .wptr_bin_sync_o  (wptr_bin_sync_o),
        .wptr_valid_o     (wptr_valid_o),
        .flush_pulse_o    (flush_pulse_o),
        .flush_ack_tgl_o  (flush_ack_tgl_o),
        .gray_err_o       (gray_err_o)
    );

    always #5 clk_out = ~clk_out;

    // Advance n rising edges, then settle 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk_out);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] to_gray(input int b);
        logic [3:0] v;
        v = 4'(b);
        return v ^ (v >> 1);
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_gsync"}, 32'(wptr_gray_sync_o), 32'h0);
        chk({tag, "_bsync"}, 32'(wptr_bin_sync_o),  32'h0);
        chk({tag, "_valid"}, 32'(wptr_valid_o),     32'h0);
        chk({tag, "_pulse"}, 32'(flush_pulse_o),    32'h0);
        chk({tag, "_ack"},   32'(flush_ack_tgl_o),  32'h0);
        chk({tag, "_err"},   32'(gray_err_o),       32'h0);
    endtask

    initial begin
        // ---------------- reset ----------------
        step(3);
        chk_all_zero("reset");
        reset = 1'b1;                       // next edge is edge 1

        // ---------------- startup blanking ----------------
        step(6);
        chk("valid_after_e6", 32'(wptr_valid_o), 32'h0);
        step(1);
        chk("valid_after_e7", 32'(wptr_valid_o), 32'h1);

        // ---------------- pointer latency ----------------
        wptr_gray_i = 4'b0001;              // sampled at edge k
        step(1);
        chk("lat_gsync_k",   32'(wptr_gray_sync_o), 32'h0);
        step(1);
        chk("lat_gsync_k1",  32'(wptr_gray_sync_o), 32'h1);
        chk("lat_bsync_k1",  32'(wptr_bin_sync_o),  32'h0);
        step(1);
        chk("lat_bsync_k2",  32'(wptr_bin_sync_o),  32'h1);

        // ---------------- Gray count, two full wraps ----------------
        for (int i = 0; i < 32; i++) begin
            wptr_gray_i = to_gray(i % 16);
            step(3);
            chk("wrap_bin",   32'(wptr_bin_sync_o),  32'(i % 16));
            chk("wrap_gsync", 32'(wptr_gray_sync_o), 32'(to_gray(i % 16)));
        end
        chk("wrap_err", 32'(gray_err_o), 32'h0);

        // ---------------- checker ----------------
        wptr_gray_i = 4'b0000; step(3);
        wptr_gray_i = 4'b0001; step(3);
        chk("chk_pre_err", 32'(gray_err_o), 32'h0);
        wptr_gray_i = 4'b0110;              // 3-bit jump
        step(1);
        chk("chk_err_early",  32'(gray_err_o),       32'h0);
        chk("chk_gsync_old",  32'(wptr_gray_sync_o), 32'h1);
        step(1);
        chk("chk_gsync_bad",  32'(wptr_gray_sync_o), 32'h6);
        chk("chk_err_set",    32'(gray_err_o),       32'h1);
        step(2);
        wptr_gray_i = 4'b0000;              // 2-bit jump, second violation
        step(1);
        err_clr_i = 1'b1;                   // coincides with the violation
        step(1);
        chk("chk_set_wins", 32'(gray_err_o), 32'h1);
        err_clr_i = 1'b0;
        step(2);
        err_clr_i = 1'b1;                   // clear alone
        step(1);
        chk("chk_clr", 32'(gray_err_o), 32'h0);
        err_clr_i = 1'b0;
        step(1);
        chk("chk_clr_hold", 32'(gray_err_o), 32'h0);

        // ---------------- flush handshake ----------------
        flush_tgl_i = 1'b1;                 // sampled at edge t
        step(1);
        chk("fl_pulse_t",  32'(flush_pulse_o), 32'h0);
        chk("fl_valid_t",  32'(wptr_valid_o),  32'h1);
        flush_tgl_i = 1'b0;                 // sampled at edge t+1
        step(1);
        chk("fl_pulse_t1", 32'(flush_pulse_o), 32'h0);
        step(1);
        chk("fl_pulse_t2", 32'(flush_pulse_o),   32'h1);
        chk("fl_ack_t2",   32'(flush_ack_tgl_o), 32'h1);
        chk("fl_valid_t2", 32'(wptr_valid_o),    32'h0);
        step(1);
        chk("fl_pulse_t3", 32'(flush_pulse_o),   32'h1);
        chk("fl_ack_t3",   32'(flush_ack_tgl_o), 32'h0);
        step(1);
        chk("fl_pulse_t4", 32'(flush_pulse_o),   32'h0);
        chk("fl_valid_t4", 32'(wptr_valid_o),    32'h0);
        step(5);
        chk("fl_valid_t9",  32'(wptr_valid_o), 32'h0);
        step(1);
        chk("fl_valid_t10", 32'(wptr_valid_o), 32'h1);

        // ---------------- flush blanking ----------------
        wptr_gray_i = 4'b0010; step(3);
        wptr_gray_i = 4'b1010; step(3);
        chk("fb_bin_pre", 32'(wptr_bin_sync_o), 32'd12);
        chk("fb_err_pre", 32'(gray_err_o),      32'h0);
        flush_tgl_i = 1'b1;                 // sampled at edge t
        step(2);
        wptr_gray_i = 4'b0000;              // multi-bit jump, sampled at t+2
        step(1);
        chk("fb_pulse", 32'(flush_pulse_o),   32'h1);
        chk("fb_ack",   32'(flush_ack_tgl_o), 32'h1);
        step(1);
        chk("fb_gsync", 32'(wptr_gray_sync_o), 32'h0);
        chk("fb_err",   32'(gray_err_o),       32'h0);
        step(10);
        chk("fb_err_late", 32'(gray_err_o),      32'h0);
        chk("fb_valid",    32'(wptr_valid_o),    32'h1);
        chk("fb_bin",      32'(wptr_bin_sync_o), 32'h0);

        // ---------------- reset during a pending flush ----------------
        wptr_gray_i = 4'b0001;
        step(3);
        chk("mf_bin_pre", 32'(wptr_bin_sync_o), 32'h1);
        flush_tgl_i = 1'b0;                 // sampled at edge m
        step(2);
        chk("mf_pulse_pre", 32'(flush_pulse_o), 32'h0);
        reset       = 1'b0;                 // write side is reset too
        wptr_gray_i = 4'b0000;
        #1;
        chk_all_zero("mf_reset");
        step(2);
        reset = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step(1);
            chk("mf_no_pulse", 32'(flush_pulse_o),   32'h0);
            chk("mf_ack_low",  32'(flush_ack_tgl_o), 32'h0);
        end
        chk("mf_valid", 32'(wptr_valid_o), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
